// File: rtl/mpsoc_pic_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register word
// offsets, source limit, ID register layout and byte-lane helper.
package mpsoc_pic_pkg;

  localparam int NUM_SRC_MAX = 32;

  localparam logic [2:0] PIC_MASK     = 3'd0;
  localparam logic [2:0] PIC_PENDING  = 3'd1;
  localparam logic [2:0] PIC_EDGE     = 3'd2;
  localparam logic [2:0] PIC_POLARITY = 3'd3;
  localparam logic [2:0] PIC_ID       = 3'd4;

  localparam int PIC_ID_VALID_BIT = 31;

  // Expands the four Wishbone byte selects into a 32-bit bit-enable mask.
  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mpsoc_pic_prio_enc.sv
// Combinational priority encoder: reports whether any request is set and the
// index of the lowest set bit.
module mpsoc_pic_prio_enc
  import mpsoc_pic_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_MAX
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [4:0]         idx_o
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/mpsoc_wb_pic.sv
// Wishbone B3 programmable interrupt controller for NUM_SRC sources with
// per-source mask, edge/level select and polarity. Optional PIC_SYNC_EN adds
// a 2-flop input synchroniser for asynchronous sources.
module mpsoc_wb_pic
  import mpsoc_pic_pkg::*;
#(
  parameter int          NUM_SRC  = 32,
  parameter logic [31:0] RST_MASK = '0,
  parameter logic [31:0] RST_EDGE = '0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [2:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic [NUM_SRC-1:0] irq_o,
  output logic               irq_any_o
);

  localparam int N = NUM_SRC;

  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] edge_q, edge_d;
  logic [N-1:0] pol_q, pol_d;
  logic [N-1:0] s_prev_q, s_prev_d;
  logic [N-1:0] irq_q, irq_d;
  logic         irq_any_q, irq_any_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;
  logic [31:0]  dat_q, dat_d;

  logic [N-1:0] src_s;
  logic [N-1:0] s_cur;
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] wmask;
  logic [N-1:0] wdat;
  logic [31:0]  lane_mask;
  logic [31:0]  rdata;
  logic         req;
  logic         mapped;
  logic         wr;
  logic         id_valid;
  logic [4:0]   id_idx;

`ifdef PIC_SYNC_EN
  logic [N-1:0] sync1_q, sync2_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src_i;
`endif

  mpsoc_pic_prio_enc #(
    .NUM_SRC (N)
  ) u_prio_enc (
    .req_i   (pend_q & mask_q),
    .valid_o (id_valid),
    .idx_o   (id_idx)
  );

  // Bus: a request is seen only while no response is outstanding, so every
  // ack/err is a single-cycle pulse and accesses take at least two cycles.
  always_comb begin
    lane_mask = sel_to_mask(wb_sel_i);
    wmask     = lane_mask[N-1:0];
    wdat      = wb_dat_i[N-1:0];
    req       = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    mapped    = (wb_adr_i <= PIC_ID);
    wr        = req & mapped & wb_we_i;
    ack_d     = req & mapped;
    err_d     = req & ~mapped;
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      PIC_MASK:     rdata = 32'(mask_q);
      PIC_PENDING:  rdata = 32'(pend_q);
      PIC_EDGE:     rdata = 32'(edge_q);
      PIC_POLARITY: rdata = 32'(pol_q);
      PIC_ID: begin
        rdata[PIC_ID_VALID_BIT] = id_valid;
        rdata[4:0]              = id_idx;
      end
      default:      rdata = '0;
    endcase
    dat_d = (req & mapped & ~wb_we_i) ? rdata : '0;
  end

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    pol_d  = pol_q;
    clr    = '0;
    if (wr) begin
      case (wb_adr_i)
        PIC_MASK:     mask_d = (mask_q & ~wmask) | (wdat & wmask);
        PIC_PENDING:  clr    = wdat & wmask;
        PIC_EDGE:     edge_d = (edge_q & ~wmask) | (wdat & wmask);
        PIC_POLARITY: pol_d  = (pol_q & ~wmask) | (wdat & wmask);
        default:      clr    = '0;
      endcase
    end
  end

  // Edge bits: sticky until cleared, with a new edge beating a same-cycle clear.
  // Level bits simply follow the polarity-corrected source.
  always_comb begin
    s_cur     = src_s ^ pol_q;
    rise      = s_cur & ~s_prev_q;
    s_prev_d  = s_cur;
    pend_d    = (edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & s_cur);
    irq_d     = pend_q & mask_q;
    irq_any_d = |irq_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      mask_q    <= RST_MASK[N-1:0];
      edge_q    <= RST_EDGE[N-1:0];
      pend_q    <= '0;
      pol_q     <= '0;
      s_prev_q  <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      mask_q    <= mask_d;
      edge_q    <= edge_d;
      pend_q    <= pend_d;
      pol_q     <= pol_d;
      s_prev_q  <= s_prev_d;
      irq_q     <= irq_d;
      irq_any_q <= irq_any_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign irq_o     = irq_q;
  assign irq_any_o = irq_any_q;

endmodule
